// File: rtl/pulse_trigger_if.sv
// Head-of-queue descriptor bus from the pulse register plus the per-cycle
// sample-control word going to the NCO/envelope datapath.
interface pulse_trigger_if #(
  parameter int ACC_W      = 32,
  parameter int AMP_W      = 16,
  parameter int TSTART_W   = 32,
  parameter int TLEN_W     = 16,
  parameter int ENV_ADDR_W = 10
) ();

  logic                  pulse_ready;
  logic                  pulse_pop;
  logic [ACC_W-1:0]      hd_freq;
  logic [ACC_W-1:0]      hd_phase;
  logic [AMP_W-1:0]      hd_amp;
  logic [TSTART_W-1:0]   hd_tstart;
  logic [TLEN_W-1:0]     hd_tlen;
  logic [ENV_ADDR_W-1:0] hd_env_addr;

  logic                  play_valid;
  logic                  play_first;
  logic                  play_last;
  logic [ACC_W-1:0]      play_phase;
  logic [AMP_W-1:0]      play_amp;
  logic [ENV_ADDR_W-1:0] play_env_addr;

  // Pulse register / datapath side: presents heads, receives pops and samples.
  modport master (
    output pulse_ready, hd_freq, hd_phase, hd_amp, hd_tstart, hd_tlen, hd_env_addr,
    input  pulse_pop, play_valid, play_first, play_last, play_phase, play_amp, play_env_addr
  );

  // Trigger side: consumes heads, issues pops and emits samples.
  modport slave (
    input  pulse_ready, hd_freq, hd_phase, hd_amp, hd_tstart, hd_tlen, hd_env_addr,
    output pulse_pop, play_valid, play_first, play_last, play_phase, play_amp, play_env_addr
  );

endinterface

// File: rtl/pulse_trigger.sv
// Pops pulse descriptors, waits for the global counter to reach each pulse's
// start time (wrap-aware), then plays it for t_len cycles emitting one
// phase/amplitude/envelope-address word per cycle. Late starts and zero-length
// descriptors are reported through sticky flags.
module pulse_trigger #(
  parameter int ACC_W      = 32,
  parameter int AMP_W      = 16,
  parameter int TSTART_W   = 32,
  parameter int TLEN_W     = 16,
  parameter int ENV_ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [TSTART_W-1:0] counter,
  pulse_trigger_if.slave      pif,
  input  logic                err_clr,
  output logic                busy,
  output logic                late_err,
  output logic                zero_len_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_PLAY
  } state_t;

  state_t state_q, state_d;

  logic [ACC_W-1:0]      freq_q;
  logic [ACC_W-1:0]      phase_q;
  logic [AMP_W-1:0]      amp_q;
  logic [TSTART_W-1:0]   tstart_q;
  logic [TLEN_W-1:0]     tlen_q;
  logic [ENV_ADDR_W-1:0] env_q;

  logic [ACC_W-1:0]      acc_q;
  logic [ENV_ADDR_W-1:0] addr_q;
  logic [TLEN_W-1:0]     rem_q;
  logic                  first_wait_q;

  logic [TSTART_W-1:0]   delta;
  logic                  reached;
  logic                  playing;
  logic                  is_last;
  logic                  pop;
  logic                  head_zero;
  logic                  set_late;
  logic                  set_zero;

  // A negative difference (top bit set) means the start time is still ahead,
  // which keeps the compare correct across counter wrap.
  assign delta     = counter - tstart_q;
  assign reached   = ~delta[TSTART_W-1];
  assign playing   = (state_q == S_PLAY);
  assign is_last   = playing && (rem_q == TLEN_W'(1));
  assign head_zero = (pif.hd_tlen == '0);
  assign pop       = ((state_q == S_IDLE) || is_last) && pif.pulse_ready && !rst_n;

  assign pif.pulse_pop     = pop;
  assign pif.play_valid    = playing;
  assign pif.play_first    = playing && (rem_q == tlen_q);
  assign pif.play_last     = is_last;
  assign pif.play_phase    = playing ? acc_q  : '0;
  assign pif.play_amp      = playing ? amp_q  : '0;
  assign pif.play_env_addr = playing ? addr_q : '0;
  assign busy              = (state_q != S_IDLE);

  // Next-state decode plus the one-cycle error set strobes.
  always_comb begin
    state_d  = state_q;
    set_late = 1'b0;
    set_zero = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          if (head_zero) set_zero = 1'b1;
          else           state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (reached) begin
          state_d = S_PLAY;
          if (first_wait_q && (delta != '0)) set_late = 1'b1;
        end
      end
      S_PLAY: begin
        if (is_last) begin
          if (pop) begin
            if (head_zero) begin
              set_zero = 1'b1;
              state_d  = S_IDLE;
            end else begin
              state_d = S_WAIT;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; first_wait_q marks the single cycle where lateness is judged.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= S_IDLE;
      first_wait_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      first_wait_q <= (state_d == S_WAIT) && (state_q != S_WAIT);
    end
  end

  // Capture the head descriptor on the pop edge only.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      freq_q   <= '0;
      phase_q  <= '0;
      amp_q    <= '0;
      tstart_q <= '0;
      tlen_q   <= '0;
      env_q    <= '0;
    end else if (pop) begin
      freq_q   <= pif.hd_freq;
      phase_q  <= pif.hd_phase;
      amp_q    <= pif.hd_amp;
      tstart_q <= pif.hd_tstart;
      tlen_q   <= pif.hd_tlen;
      env_q    <= pif.hd_env_addr;
    end
  end

  // Phase accumulator, envelope address and remaining-length countdown.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      acc_q  <= '0;
      addr_q <= '0;
      rem_q  <= '0;
    end else if ((state_q == S_WAIT) && reached) begin
      acc_q  <= phase_q;
      addr_q <= env_q;
      rem_q  <= tlen_q;
    end else if (playing) begin
      acc_q  <= acc_q + freq_q;
      addr_q <= addr_q + ENV_ADDR_W'(1);
      rem_q  <= rem_q - TLEN_W'(1);
    end
  end

  // Sticky error flags; a new event takes priority over a clear.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      late_err     <= 1'b0;
      zero_len_err <= 1'b0;
    end else begin
      late_err     <= set_late | (late_err & ~err_clr);
      zero_len_err <= set_zero | (zero_len_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_pulse_trigger.sv
// Directed bench for pulse_trigger: a queue models the pulse register, every
// cycle's pops and samples are logged at the falling edge and compared
// against hand-computed values.
module tb_pulse_trigger;

  typedef struct packed {
    logic [31:0] freq;
    logic [31:0] phase;
    logic [15:0] amp;
    logic [31:0] tstart;
    logic [15:0] tlen;
    logic [9:0]  env;
  } head_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] counter;
  logic        err_clr;
  logic        busy;
  logic        late_err;
  logic        zero_len_err;

  pulse_trigger_if pif ();

  pulse_trigger dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .counter      (counter),
    .pif          (pif),
    .err_clr      (err_clr),
    .busy         (busy),
    .late_err     (late_err),
    .zero_len_err (zero_len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assert_count = 0;
  int fail_count   = 0;

  head_t       head_q[$];
  logic [31:0] pop_ctr[$];
  logic [31:0] smp_ctr[$];
  logic [31:0] smp_phase[$];
  logic [9:0]  smp_env[$];
  logic [15:0] smp_amp[$];
  logic        smp_first[$];
  logic        smp_last[$];

  logic        snap_pop, snap_valid, snap_first, snap_last, snap_busy, snap_late, snap_zero;
  logic [31:0] snap_phase;
  logic [15:0] snap_amp;
  logic [9:0]  snap_env;

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic head_t mkHead(input logic [31:0] freq, input logic [31:0] phase,
                                   input logic [15:0] amp, input logic [31:0] tstart,
                                   input logic [15:0] tlen, input logic [9:0] env);
    head_t h;
    h.freq = freq; h.phase = phase; h.amp = amp;
    h.tstart = tstart; h.tlen = tlen; h.env = env;
    return h;
  endfunction

  task automatic driveHead();
    if (head_q.size() != 0) begin
      pif.pulse_ready = 1'b1;
      pif.hd_freq     = head_q[0].freq;
      pif.hd_phase    = head_q[0].phase;
      pif.hd_amp      = head_q[0].amp;
      pif.hd_tstart   = head_q[0].tstart;
      pif.hd_tlen     = head_q[0].tlen;
      pif.hd_env_addr = head_q[0].env;
    end else begin
      pif.pulse_ready = 1'b0;
      pif.hd_freq     = '0;
      pif.hd_phase    = '0;
      pif.hd_amp      = '0;
      pif.hd_tstart   = '0;
      pif.hd_tlen     = '0;
      pif.hd_env_addr = '0;
    end
  endtask

  task automatic clearLog();
    pop_ctr.delete();
    smp_ctr.delete();
    smp_phase.delete();
    smp_env.delete();
    smp_amp.delete();
    smp_first.delete();
    smp_last.delete();
  endtask

  // One clock cycle: snapshot and log at the falling edge, then after the
  // rising edge retire a popped head, advance the counter and redrive.
  task automatic applyStimulus();
    @(negedge clk);
    snap_pop   = pif.pulse_pop;
    snap_valid = pif.play_valid;
    snap_first = pif.play_first;
    snap_last  = pif.play_last;
    snap_phase = pif.play_phase;
    snap_amp   = pif.play_amp;
    snap_env   = pif.play_env_addr;
    snap_busy  = busy;
    snap_late  = late_err;
    snap_zero  = zero_len_err;
    if (snap_pop) pop_ctr.push_back(counter);
    if (snap_valid) begin
      smp_ctr.push_back(counter);
      smp_phase.push_back(snap_phase);
      smp_env.push_back(snap_env);
      smp_amp.push_back(snap_amp);
      smp_first.push_back(snap_first);
      smp_last.push_back(snap_last);
    end
    @(posedge clk);
    #1;
    if (snap_pop && head_q.size() != 0) void'(head_q.pop_front());
    counter = counter + 32'd1;
    driveHead();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic checkSample(input string tag, input int k, input logic [31:0] ctr,
                             input logic [31:0] phase, input logic [9:0] env,
                             input logic [15:0] amp, input logic first, input logic last);
    if (k >= smp_ctr.size()) begin
      checkOutput($sformatf("%s_s%0d_present", tag, k), 64'(smp_ctr.size()), 64'(k + 1));
    end else begin
      checkOutput($sformatf("%s_s%0d_ctr", tag, k),   64'(smp_ctr[k]),   64'(ctr));
      checkOutput($sformatf("%s_s%0d_phase", tag, k), 64'(smp_phase[k]), 64'(phase));
      checkOutput($sformatf("%s_s%0d_env", tag, k),   64'(smp_env[k]),   64'(env));
      checkOutput($sformatf("%s_s%0d_amp", tag, k),   64'(smp_amp[k]),   64'(amp));
      checkOutput($sformatf("%s_s%0d_first", tag, k), 64'(smp_first[k]), 64'(first));
      checkOutput($sformatf("%s_s%0d_last", tag, k),  64'(smp_last[k]),  64'(last));
    end
  endtask

  task automatic checkPop(input string tag, input int k, input logic [31:0] ctr);
    if (k >= pop_ctr.size())
      checkOutput($sformatf("%s_pop%0d_present", tag, k), 64'(pop_ctr.size()), 64'(k + 1));
    else
      checkOutput($sformatf("%s_pop%0d_ctr", tag, k), 64'(pop_ctr[k]), 64'(ctr));
  endtask

  task automatic clearErrors();
    err_clr = 1'b1;
    applyStimulus();
    err_clr = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b1;
    err_clr = 1'b0;
    counter = 32'd0;
    head_q.push_back(mkHead(32'h10, 32'h5, 16'h1234, 32'd100, 16'd4, 10'h3FE));
    driveHead();

    // Reset state, with a head already waiting: nothing may be popped.
    $display("[TB] reset");
    runCycles(2);
    checkOutput("rst_pop",   64'(snap_pop),   64'd0);
    checkOutput("rst_valid", 64'(snap_valid), 64'd0);
    checkOutput("rst_first", 64'(snap_first), 64'd0);
    checkOutput("rst_last",  64'(snap_last),  64'd0);
    checkOutput("rst_phase", 64'(snap_phase), 64'd0);
    checkOutput("rst_amp",   64'(snap_amp),   64'd0);
    checkOutput("rst_env",   64'(snap_env),   64'd0);
    checkOutput("rst_busy",  64'(snap_busy),  64'd0);
    checkOutput("rst_late",  64'(snap_late),  64'd0);
    checkOutput("rst_zero",  64'(snap_zero),  64'd0);

    // Basic pulse: tstart 100, plays at counter 101..104, env address wraps.
    $display("[TB] basic pulse");
    rst_n   = 1'b0;
    counter = 32'd0;
    clearLog();
    runCycles(110);
    checkOutput("basic_pops", 64'(pop_ctr.size()), 64'd1);
    checkPop("basic", 0, 32'd0);
    checkOutput("basic_nsmp", 64'(smp_ctr.size()), 64'd4);
    checkSample("basic", 0, 32'd101, 32'h05, 10'h3FE, 16'h1234, 1'b1, 1'b0);
    checkSample("basic", 1, 32'd102, 32'h15, 10'h3FF, 16'h1234, 1'b0, 1'b0);
    checkSample("basic", 2, 32'd103, 32'h25, 10'h000, 16'h1234, 1'b0, 1'b0);
    checkSample("basic", 3, 32'd104, 32'h35, 10'h001, 16'h1234, 1'b0, 1'b1);
    checkOutput("basic_late", 64'(snap_late), 64'd0);
    checkOutput("basic_zero", 64'(snap_zero), 64'd0);
    checkOutput("basic_busy_end", 64'(snap_busy), 64'd0);

    // Late pulse: tstart 10 presented at counter 50.
    $display("[TB] late pulse");
    counter = 32'd50;
    clearLog();
    head_q.push_back(mkHead(32'h3, 32'h100, 16'h7, 32'd10, 16'd2, 10'h10));
    driveHead();
    runCycles(5);
    checkPop("late", 0, 32'd50);
    checkOutput("late_nsmp", 64'(smp_ctr.size()), 64'd2);
    checkSample("late", 0, 32'd52, 32'h100, 10'h10, 16'h7, 1'b1, 1'b0);
    checkSample("late", 1, 32'd53, 32'h103, 10'h11, 16'h7, 1'b0, 1'b1);
    checkOutput("late_flag", 64'(snap_late), 64'd1);
    clearErrors();
    checkOutput("late_during_clr", 64'(snap_late), 64'd1);
    applyStimulus();
    checkOutput("late_cleared", 64'(snap_late), 64'd0);

    // Zero-length head is dropped, then a normal pulse follows.
    $display("[TB] zero length");
    counter = 32'd200;
    clearLog();
    head_q.push_back(mkHead(32'h1, 32'h0, 16'h1, 32'd205, 16'd0, 10'h0));
    head_q.push_back(mkHead(32'h1, 32'h40, 16'h9, 32'd210, 16'd2, 10'h100));
    driveHead();
    runCycles(2);
    checkOutput("zero_flag",  64'(snap_zero),  64'd1);
    checkOutput("zero_busy",  64'(snap_busy),  64'd0);
    checkOutput("zero_valid", 64'(snap_valid), 64'd0);
    runCycles(14);
    checkOutput("zero_pops", 64'(pop_ctr.size()), 64'd2);
    checkPop("zero", 0, 32'd200);
    checkPop("zero", 1, 32'd201);
    checkOutput("zero_nsmp", 64'(smp_ctr.size()), 64'd2);
    checkSample("zero", 0, 32'd211, 32'h40, 10'h100, 16'h9, 1'b1, 1'b0);
    checkSample("zero", 1, 32'd212, 32'h41, 10'h101, 16'h9, 1'b0, 1'b1);
    checkOutput("zero_no_late", 64'(snap_late), 64'd0);
    clearErrors();
    applyStimulus();
    checkOutput("zero_cleared", 64'(snap_zero), 64'd0);

    // Back-to-back: second pop on the first pulse's last sample, one gap cycle.
    $display("[TB] back-to-back");
    counter = 32'd15;
    clearLog();
    head_q.push_back(mkHead(32'h100, 32'h0,  16'h1, 32'd20, 16'd3, 10'h20));
    head_q.push_back(mkHead(32'h2,   32'h50, 16'h2, 32'd20, 16'd3, 10'h40));
    driveHead();
    runCycles(9);
    checkOutput("b2b_late_before", 64'(snap_late), 64'd0);
    checkOutput("b2b_pop_on_last", 64'(snap_pop && snap_last), 64'd1);
    applyStimulus();
    checkOutput("b2b_gap_busy",  64'(snap_busy),  64'd1);
    checkOutput("b2b_gap_valid", 64'(snap_valid), 64'd0);
    runCycles(5);
    checkOutput("b2b_late_after", 64'(snap_late), 64'd1);
    checkOutput("b2b_pops", 64'(pop_ctr.size()), 64'd2);
    checkPop("b2b", 0, 32'd15);
    checkPop("b2b", 1, 32'd23);
    checkOutput("b2b_nsmp", 64'(smp_ctr.size()), 64'd6);
    checkSample("b2b", 0, 32'd21, 32'h000, 10'h20, 16'h1, 1'b1, 1'b0);
    checkSample("b2b", 1, 32'd22, 32'h100, 10'h21, 16'h1, 1'b0, 1'b0);
    checkSample("b2b", 2, 32'd23, 32'h200, 10'h22, 16'h1, 1'b0, 1'b1);
    checkSample("b2b", 3, 32'd25, 32'h50,  10'h40, 16'h2, 1'b1, 1'b0);
    checkSample("b2b", 4, 32'd26, 32'h52,  10'h41, 16'h2, 1'b0, 1'b0);
    checkSample("b2b", 5, 32'd27, 32'h54,  10'h42, 16'h2, 1'b0, 1'b1);
    clearErrors();

    // Counter wrap: start time lies just past the wrap point.
    $display("[TB] counter wrap");
    counter = 32'hFFFF_FFF0;
    clearLog();
    head_q.push_back(mkHead(32'h11, 32'h0, 16'h3, 32'h0000_0005, 16'd2, 10'h0));
    driveHead();
    runCycles(25);
    checkPop("wrap", 0, 32'hFFFF_FFF0);
    checkOutput("wrap_nsmp", 64'(smp_ctr.size()), 64'd2);
    checkSample("wrap", 0, 32'd6, 32'h00, 10'h0, 16'h3, 1'b1, 1'b0);
    checkSample("wrap", 1, 32'd7, 32'h11, 10'h1, 16'h3, 1'b0, 1'b1);
    checkOutput("wrap_no_late", 64'(snap_late), 64'd0);

    // Reset on sample 2 of an 8-sample pulse with another head queued.
    $display("[TB] reset mid-play");
    counter = 32'd300;
    clearLog();
    head_q.push_back(mkHead(32'h4, 32'h0, 16'h5, 32'd302, 16'd8, 10'h0));
    driveHead();
    runCycles(5);
    head_q.push_back(mkHead(32'h1, 32'h77, 16'h6, 32'd0, 16'd1, 10'h5));
    driveHead();
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("mid_rst_phase", 64'(snap_phase), 64'h8);
    checkOutput("mid_rst_pop",   64'(snap_pop),   64'd0);
    rst_n = 1'b0;
    applyStimulus();
    checkOutput("mid_after_valid", 64'(snap_valid), 64'd0);
    checkOutput("mid_after_first", 64'(snap_first), 64'd0);
    checkOutput("mid_after_last",  64'(snap_last),  64'd0);
    checkOutput("mid_after_phase", 64'(snap_phase), 64'd0);
    checkOutput("mid_after_amp",   64'(snap_amp),   64'd0);
    checkOutput("mid_after_env",   64'(snap_env),   64'd0);
    checkOutput("mid_after_busy",  64'(snap_busy),  64'd0);
    checkOutput("mid_after_late",  64'(snap_late),  64'd0);
    checkOutput("mid_after_pop",   64'(snap_pop),   64'd1);
    runCycles(3);
    checkOutput("mid_pops", 64'(pop_ctr.size()), 64'd2);
    checkPop("mid", 0, 32'd300);
    checkPop("mid", 1, 32'd306);
    checkOutput("mid_nsmp", 64'(smp_ctr.size()), 64'd4);
    checkSample("mid", 0, 32'd303, 32'h0,  10'h0, 16'h5, 1'b1, 1'b0);
    checkSample("mid", 1, 32'd304, 32'h4,  10'h1, 16'h5, 1'b0, 1'b0);
    checkSample("mid", 2, 32'd305, 32'h8,  10'h2, 16'h5, 1'b0, 1'b0);
    checkSample("mid", 3, 32'd308, 32'h77, 10'h5, 16'h6, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/pulse_trigger.md
# pulse_trigger

Downstream consumer of the pulse register inside the pulse scheduler. It pops the head pulse descriptor, waits until the global time counter reaches the pulse's `t_start`, then plays the pulse for `t_len` cycles. During playback it emits one sample-control word per cycle (accumulated phase, amplitude, envelope address) to the NCO/envelope datapath. It also flags pulses that arrive after their start time.

## Interface
Parameters:
- `ACC_W`, 32: frequency-word and phase-accumulator width (frequency and phase share this width).
- `AMP_W`, 16: amplitude width.
- `TSTART_W`, 32: start-time width; equals the counter width.
- `TLEN_W`, 16: pulse length width, in cycles.
- `ENV_ADDR_W`, 10: envelope memory address width.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset; synchronous, active-high.
- `counter`, in, TSTART_W: global free-running time counter.
- `pulse_ready`, in, 1: pulse register head entry is valid.
- `pulse_pop`, out, 1: one-cycle pop strobe to the pulse register.
- `hd_freq`, in, ACC_W: head entry frequency tuning word.
- `hd_phase`, in, ACC_W: head entry initial phase.
- `hd_amp`, in, AMP_W: head entry amplitude.
- `hd_tstart`, in, TSTART_W: head entry start time.
- `hd_tlen`, in, TLEN_W: head entry length.
- `hd_env_addr`, in, ENV_ADDR_W: head entry envelope base address.
- `play_valid`, out, 1: sample-control word valid this cycle.
- `play_first`, out, 1: first sample of a pulse.
- `play_last`, out, 1: last sample of a pulse.
- `play_phase`, out, ACC_W: accumulated phase.
- `play_amp`, out, AMP_W: amplitude.
- `play_env_addr`, out, ENV_ADDR_W: envelope address.
- `busy`, out, 1: high in WAIT or PLAY.
- `late_err`, out, 1: sticky flag, set when a pulse starts late.
- `zero_len_err`, out, 1: sticky flag, set when a `t_len = 0` pulse is dropped.
- `err_clr`, in, 1: clears both sticky flags.

## Operation
FSM states: IDLE, WAIT, PLAY.

- **IDLE**
  - If `pulse_ready`: assert `pulse_pop` for one cycle and latch all `hd_*` fields in the same cycle.
  - If the latched `hd_tlen == 0`: set `zero_len_err` and stay in IDLE. Otherwise go to WAIT.
- **WAIT**
  - Compute `d = counter - t_start`, mod 2^TSTART_W. The start time is reached when `d[TSTART_W-1] == 0`; this compare is wrap-aware.
  - When reached: go to PLAY, load `acc = phase`, `addr = env_addr`, `rem = t_len`.
  - If `d != 0` on the first WAIT cycle, set `late_err`; the pulse still plays immediately.
- **PLAY**, every cycle:
  - Outputs:
    - `play_valid = 1`.
    - `play_phase = acc`, `play_amp = amp`, `play_env_addr = addr`.
    - `play_first` is high when `rem == t_len`.
    - `play_last` is high when `rem == 1`.
  - Register updates:
    - `acc += freq`, mod 2^ACC_W.
    - `addr += 1`, wrapping mod 2^ENV_ADDR_W.
    - `rem -= 1`.
  - On the `play_last` cycle:
    - If `pulse_ready`: pop and latch the next head in the same cycle, then go to WAIT, or to IDLE with `zero_len_err` set if that head has `t_len = 0`.
    - Otherwise go to IDLE.
- **Head fields:** `hd_*` are ignored except in the pop cycle. A new descriptor is never popped during WAIT or non-last PLAY cycles.
- **Sticky flags:** `err_clr` clears both flags. If `err_clr` and a set condition occur in the same cycle, set wins.
- **Reset:** `rst_n` high at any point, including mid-PLAY, returns the FSM to IDLE. The current pulse is abandoned and no pop is issued in the reset cycle.

## Timing
- **Reset values:** all outputs 0 (`pulse_pop`, `play_*`, `busy`, `late_err`, `zero_len_err`); FSM in IDLE.
- **Pop:** `pulse_pop` is combinational from state and `pulse_ready`. Fields are latched on the same clock edge.
- **Start latency:** if WAIT sees `d` reached at cycle N, the first `play_valid` is registered high in cycle N+1. With `counter == t_start` at cycle N, the sample appears when the counter reads `t_start + 1`; downstream compensates with a fixed 1-cycle offset.
- **Minimum path:** pop in cycle P → WAIT from P+1 → earliest `play_valid` at P+2.
- **Playback:** `play_valid` is high for exactly `t_len` consecutive cycles. `play_phase` on sample k (0-based) equals `phase + k*freq` mod 2^ACC_W.
- **Back-to-back pulses:** one gap cycle minimum between pulses (the WAIT evaluation cycle), even for late pulses.
- **`busy`:** registered; high from the cycle after the pop through the `play_last` cycle.

## Test plan
- **Basic pulse:** reset, head `tstart = 100`, `tlen = 4`, `freq = 0x10`, `phase = 0x5`, `env = 0x3FE`, counter from 0.
  - One `pulse_pop`.
  - `play_valid` at counter 101–104.
  - `play_phase` = 0x5, 0x15, 0x25, 0x35.
  - `play_env_addr` = 0x3FE, 0x3FF, 0x000, 0x001.
  - `play_first` on sample 0, `play_last` on sample 3, no errors.
- **Late pulse:** head `tstart = 10` presented at counter 50, `tlen = 2`.
  - `late_err = 1`.
  - Two samples starting 2 cycles after the pop.
  - `err_clr` → `late_err = 0`.
- **Zero length:** head `tlen = 0`.
  - One pop, `zero_len_err = 1`, no `play_valid`, `busy = 0`.
  - Then a valid pulse plays normally.
- **Back-to-back:** two heads, `tstart` = 20 and 20, `tlen = 3`, `pulse_ready` held.
  - Second pop coincides with the first pulse's `play_last`.
  - Second pulse flags `late_err` and plays after one gap cycle.
- **Counter wrap:** counter at 0xFFFF_FFF0, head `tstart = 0x0000_0005`.
  - No start before wrap.
  - `play_valid` when the counter reads 0x0000_0006.
  - No `late_err`.
- **Reset mid-play:** assert `rst_n` on sample 2 of `tlen = 8`.
  - Next cycle: all outputs 0, IDLE.
  - No pop during the reset cycle; a queued head is popped after reset deasserts.
